// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: BCD time and alarm keeping, set-mode FSM, hourly chime and alarm.
// All display and status outputs are registered from next-state values.
module clock_set_ctrl #(
    parameter int TIMEOUT_S  = 10,
    parameter int HOURLY_LEN = 2,
    parameter int ALARM_LEN  = 30
) (
    input  logic        clk,
    input  logic        rst_N,
    input  logic        tick_1hz,
    input  logic        key_mode,
    input  logic        key_inc,
    input  logic        alarm_on,
    output logic [23:0] number_BCD,
    output logic [2:0]  DTube_en,
    output logic [2:0]  Twinkle_en,
    output logic        HOURLY,
    output logic        ALARM,
    output logic [2:0]  mode
);

    typedef enum logic [2:0] {
        RUN   = 3'd0,
        SET_H = 3'd1,
        SET_M = 3'd2,
        SET_S = 3'd3,
        ALM_H = 3'd4,
        ALM_M = 3'd5
    } state_t;

    localparam int TW = $clog2(TIMEOUT_S + 1);
    localparam int HW = $clog2(HOURLY_LEN + 1);
    localparam int AW = $clog2(ALARM_LEN + 1);

    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_S - 1);
    localparam logic [HW-1:0] HR_LOAD = HW'(HOURLY_LEN);
    localparam logic [AW-1:0] AL_LOAD = AW'(ALARM_LEN);

    state_t        state;
    state_t        state_n;
    logic [TW-1:0] tcnt;
    logic [TW-1:0] tcnt_n;
    logic [HW-1:0] hcnt;
    logic [HW-1:0] hcnt_n;
    logic [AW-1:0] acnt;
    logic [AW-1:0] acnt_n;

    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic [7:0] ah;
    logic [7:0] am;
    logic [7:0] hh_n;
    logic [7:0] mm_n;
    logic [7:0] ss_n;
    logic [7:0] ah_n;
    logic [7:0] am_n;

    logic key_any;
    logic ack;
    logic mode_ev;
    logic inc_ev;
    logic in_set;
    logic time_run;
    logic hour_roll;
    logic alarm_hit;
    logic alm_view;

    logic [23:0] disp_n;
    logic [2:0]  dtube_n;
    logic [2:0]  twinkle_n;

    // Two-digit BCD increment that wraps to 00 after top.
    function automatic logic [7:0] bcd_inc(
        input logic [7:0] v,
        input logic [7:0] top
    );
        if (v == top) begin
            return 8'h00;
        end else if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end else begin
            return v + 8'd1;
        end
    endfunction

    assign mode = state;

    // Key qualification: a key during a ringing alarm only silences it.
    always_comb begin
        key_any  = key_mode | key_inc;
        ack      = ALARM & key_any;
        mode_ev  = key_mode & ~ack;
        inc_ev   = key_inc & ~key_mode & ~ack;
        in_set   = (state == SET_H) || (state == SET_M) ||
                   (state == SET_S) || (state == ALM_H) ||
                   (state == ALM_M);
        time_run = tick_1hz &&
                   ((state == RUN) || (state == ALM_H) ||
                    (state == ALM_M));
    end

    // Mode sequencing plus idle timeout back to RUN; keys beat the timeout.
    always_comb begin
        state_n = state;
        tcnt_n  = '0;
        case (state)
            RUN:     if (mode_ev) state_n = SET_H;
            SET_H:   if (mode_ev) state_n = SET_M;
            SET_M:   if (mode_ev) state_n = SET_S;
            SET_S:   if (mode_ev) state_n = ALM_H;
            ALM_H:   if (mode_ev) state_n = ALM_M;
            ALM_M:   if (mode_ev) state_n = RUN;
            default: state_n = RUN;
        endcase
        if (in_set && !key_any) begin
            tcnt_n = tcnt;
            if (tick_1hz) begin
                if (tcnt == TO_LAST) begin
                    state_n = RUN;
                    tcnt_n  = '0;
                end else begin
                    tcnt_n = tcnt + TW'(1);
                end
            end
        end
    end

    // Next time and alarm: 1 Hz ripple outside SET_*, key edits per state.
    always_comb begin
        hh_n = hh;
        mm_n = mm;
        ss_n = ss;
        ah_n = ah;
        am_n = am;
        if (time_run) begin
            ss_n = bcd_inc(ss, 8'h59);
            if (ss == 8'h59) begin
                mm_n = bcd_inc(mm, 8'h59);
                if (mm == 8'h59) begin
                    hh_n = bcd_inc(hh, 8'h23);
                end
            end
        end
        if (inc_ev) begin
            case (state)
                SET_H:   hh_n = bcd_inc(hh, 8'h23);
                SET_M:   mm_n = bcd_inc(mm, 8'h59);
                SET_S:   ss_n = bcd_inc(ss, 8'h59);
                ALM_H:   ah_n = bcd_inc(ah, 8'h23);
                ALM_M:   am_n = bcd_inc(am, 8'h59);
                default: ;
            endcase
        end
    end

    // Chime and alarm length counters; only tick-driven time can trigger them.
    always_comb begin
        hour_roll = time_run && (ss == 8'h59) && (mm == 8'h59);
        alarm_hit = time_run && alarm_on &&
                    (hh_n == ah) && (mm_n == am) &&
                    (ss_n == 8'h00);
        hcnt_n = hcnt;
        if (hour_roll) begin
            hcnt_n = HR_LOAD;
        end else if (tick_1hz && (hcnt != '0)) begin
            hcnt_n = hcnt - HW'(1);
        end
        acnt_n = acnt;
        if (!alarm_on) begin
            acnt_n = '0;
        end else if (alarm_hit) begin
            acnt_n = AL_LOAD;
        end else if (ack) begin
            acnt_n = '0;
        end else if (tick_1hz && (acnt != '0)) begin
            acnt_n = acnt - AW'(1);
        end
    end

    // Display view for the state being entered: alarm digits in ALM_*.
    always_comb begin
        alm_view  = (state_n == ALM_H) || (state_n == ALM_M);
        disp_n    = alm_view ? {ah_n, am_n, 8'h00} : {hh_n, mm_n, ss_n};
        dtube_n   = alm_view ? 3'b110 : 3'b111;
        twinkle_n = 3'b000;
        case (state_n)
            SET_H, ALM_H: twinkle_n = 3'b100;
            SET_M, ALM_M: twinkle_n = 3'b010;
            SET_S:        twinkle_n = 3'b001;
            default:      twinkle_n = 3'b000;
        endcase
    end

    // FSM state and timeout counter register.
    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            state <= RUN;
            tcnt  <= '0;
        end else begin
            state <= state_n;
            tcnt  <= tcnt_n;
        end
    end

    // Time, alarm, chime counters and registered display outputs.
    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            hh         <= 8'h00;
            mm         <= 8'h00;
            ss         <= 8'h00;
            ah         <= 8'h06;
            am         <= 8'h00;
            hcnt       <= '0;
            acnt       <= '0;
            number_BCD <= 24'h000000;
            DTube_en   <= 3'b111;
            Twinkle_en <= 3'b000;
            HOURLY     <= 1'b0;
            ALARM      <= 1'b0;
        end else begin
            hh         <= hh_n;
            mm         <= mm_n;
            ss         <= ss_n;
            ah         <= ah_n;
            am         <= am_n;
            hcnt       <= hcnt_n;
            acnt       <= acnt_n;
            number_BCD <= disp_n;
            DTube_en   <= dtube_n;
            Twinkle_en <= twinkle_n;
            HOURLY     <= (hcnt_n != '0);
            ALARM      <= (acnt_n != '0);
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed scenarios for clock_set_ctrl.
// Expected outputs are queued with a due cycle and compared at the falling edge.
module tb_clock_set_ctrl;

    logic        clk = 1'b0;
    logic        rst_N;
    logic        tick_1hz;
    logic        key_mode;
    logic        key_inc;
    logic        alarm_on;
    logic [23:0] number_BCD;
    logic [2:0]  DTube_en;
    logic [2:0]  Twinkle_en;
    logic        HOURLY;
    logic        ALARM;
    logic [2:0]  mode;

    clock_set_ctrl dut (
        .clk       (clk),
        .rst_N     (rst_N),
        .tick_1hz  (tick_1hz),
        .key_mode  (key_mode),
        .key_inc   (key_inc),
        .alarm_on  (alarm_on),
        .number_BCD(number_BCD),
        .DTube_en  (DTube_en),
        .Twinkle_en(Twinkle_en),
        .HOURLY    (HOURLY),
        .ALARM     (ALARM),
        .mode      (mode)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          due;
        logic [23:0] bcd;
        logic [2:0]  dt;
        logic [2:0]  tw;
        logic        hr;
        logic        al;
        logic [2:0]  md;
    } exp_t;

    exp_t sb[$];
    exp_t m;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: pop every entry due by now and compare against the DUT.
    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].due <= cyc) begin
            m = sb.pop_front();
            tests++;
            if (m.due != cyc) begin
                fails++;
                $display("FAIL %s: stale entry due %0d seen at %0d",
                         m.name, m.due, cyc);
            end else if ({number_BCD, DTube_en, Twinkle_en,
                          HOURLY, ALARM, mode} !==
                         {m.bcd, m.dt, m.tw, m.hr, m.al, m.md}) begin
                fails++;
                $display("FAIL %s: got bcd=%h dt=%b tw=%b hr=%b al=%b md=%0d, want bcd=%h dt=%b tw=%b hr=%b al=%b md=%0d",
                         m.name, number_BCD, DTube_en, Twinkle_en,
                         HOURLY, ALARM, mode, m.bcd, m.dt, m.tw,
                         m.hr, m.al, m.md);
            end
        end
    end

    function automatic logic [7:0] b2(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    task automatic want(input string nm, input int lag,
                        input logic [23:0] bcd, input logic [2:0] dt,
                        input logic [2:0] tw, input logic hr,
                        input logic al, input logic [2:0] md);
        exp_t e;
        e.name = nm;
        e.due  = cyc + lag;
        e.bcd  = bcd;
        e.dt   = dt;
        e.tw   = tw;
        e.hr   = hr;
        e.al   = al;
        e.md   = md;
        sb.push_back(e);
    endtask

    task automatic want_run(input string nm, input logic [23:0] bcd,
                            input logic hr, input logic al);
        want(nm, 1, bcd, 3'b111, 3'b000, hr, al, 3'd0);
    endtask

    task automatic step(input logic t, input logic km, input logic ki);
        tick_1hz = t;
        key_mode = km;
        key_inc  = ki;
        @(posedge clk);
        #1;
        tick_1hz = 1'b0;
        key_mode = 1'b0;
        key_inc  = 1'b0;
    endtask

    // Walk the set states from RUN to reach a target time, then back to RUN.
    task automatic set_time(input int ch, input int cm, input int cs,
                            input int th, input int tm, input int ts);
        step(0, 1, 0);
        repeat ((th - ch + 24) % 24) step(0, 0, 1);
        step(0, 1, 0);
        repeat ((tm - cm + 60) % 60) step(0, 0, 1);
        step(0, 1, 0);
        repeat ((ts - cs + 60) % 60) step(0, 0, 1);
        repeat (3) step(0, 1, 0);
    endtask

    task automatic test_reset;
        rst_N    = 1'b0;
        tick_1hz = 1'b0;
        key_mode = 1'b0;
        key_inc  = 1'b0;
        alarm_on = 1'b0;
        @(posedge clk);
        #1;
        want("reset values", 0, 24'h000000, 3'b111, 3'b000, 0, 0, 3'd0);
        @(posedge clk);
        #1;
        rst_N = 1'b1;
        want_run("idle after reset", 24'h000000, 0, 0);
        step(0, 0, 0);
    endtask

    task automatic test_rollover;
        set_time(0, 0, 0, 23, 59, 58);
        want_run("time loaded", 24'h235958, 0, 0);
        step(0, 0, 0);
        want_run("tick to 59", 24'h235959, 0, 0);
        step(1, 0, 0);
        want_run("day rollover", 24'h000000, 1, 0);
        step(1, 0, 0);
        want_run("chime idle hold", 24'h000000, 1, 0);
        step(0, 0, 0);
        want_run("chime second tick", 24'h000001, 1, 0);
        step(1, 0, 0);
        want_run("chime ends", 24'h000002, 0, 0);
        step(1, 0, 0);
    endtask

    task automatic test_set_hour;
        want("enter set_h", 1, 24'h000002, 3'b111, 3'b100, 0, 0, 3'd1);
        step(0, 1, 0);
        for (int i = 1; i <= 3; i++) begin
            want("hour inc", 1, {b2(i), 16'h0002},
                 3'b111, 3'b100, 0, 0, 3'd1);
            step(0, 0, 1);
        end
        want("tick frozen set_h", 1, 24'h030002,
             3'b111, 3'b100, 0, 0, 3'd1);
        step(1, 0, 0);
        want("enter set_m", 1, 24'h030002, 3'b111, 3'b010, 0, 0, 3'd2);
        step(0, 1, 0);
    endtask

    task automatic test_set_min;
        repeat (58) step(0, 0, 1);
        want("minute 59", 1, 24'h035902, 3'b111, 3'b010, 0, 0, 3'd2);
        step(0, 0, 1);
        want("minute wrap", 1, 24'h030002, 3'b111, 3'b010, 0, 0, 3'd2);
        step(0, 0, 1);
        want("mode beats inc", 1, 24'h030002, 3'b111, 3'b001, 0, 0, 3'd3);
        step(0, 1, 1);
        want("second inc", 1, 24'h030003, 3'b111, 3'b001, 0, 0, 3'd3);
        step(0, 0, 1);
        want("enter alm_h", 1, 24'h060000, 3'b110, 3'b100, 0, 0, 3'd4);
        step(0, 1, 0);
    endtask

    task automatic test_timeout;
        for (int i = 1; i <= 9; i++) begin
            want("timeout pending", 1, 24'h060000,
                 3'b110, 3'b100, 0, 0, 3'd4);
            step(1, 0, 0);
        end
        want_run("timeout to run", 24'h030013, 0, 0);
        step(1, 0, 0);
    endtask

    task automatic test_alarm;
        alarm_on = 1'b1;
        set_time(3, 0, 13, 5, 59, 59);
        want_run("alarm match", 24'h060000, 1, 1);
        step(1, 0, 0);
        want_run("inc silences alarm", 24'h060000, 1, 0);
        step(0, 0, 1);
        want_run("post clear tick", 24'h060001, 1, 0);
        step(1, 0, 0);
        want_run("post clear tick 2", 24'h060002, 0, 0);
        step(1, 0, 0);

        set_time(6, 0, 2, 5, 59, 59);
        want_run("alarm match 2", 24'h060000, 1, 1);
        step(1, 0, 0);
        want_run("mode key consumed", 24'h060000, 1, 0);
        step(0, 1, 0);

        set_time(6, 0, 0, 5, 59, 59);
        want_run("alarm match 3", 24'h060000, 1, 1);
        step(1, 0, 0);
        alarm_on = 1'b0;
        want_run("alarm_on low clears", 24'h060000, 1, 0);
        step(0, 0, 0);

        set_time(6, 0, 0, 5, 59, 59);
        alarm_on = 1'b1;
        want_run("alarm match 4", 24'h060000, 1, 1);
        step(1, 0, 0);
        repeat (28) step(1, 0, 0);
        want_run("alarm last tick", 24'h060029, 0, 1);
        step(1, 0, 0);
        want_run("alarm expires", 24'h060030, 0, 0);
        step(1, 0, 0);
        alarm_on = 1'b0;
    endtask

    task automatic test_timeout_key;
        repeat (3) step(0, 1, 0);
        want("alm_h again", 1, 24'h060000, 3'b110, 3'b100, 0, 0, 3'd4);
        step(0, 1, 0);
        repeat (9) step(1, 0, 0);
        want("key beats timeout", 1, 24'h070000,
             3'b110, 3'b100, 0, 0, 3'd4);
        step(1, 0, 1);
        repeat (8) step(1, 0, 0);
        want("count restarted", 1, 24'h070000,
             3'b110, 3'b100, 0, 0, 3'd4);
        step(1, 0, 0);
        want_run("timeout after restart", 24'h060050, 0, 0);
        step(1, 0, 0);
    endtask

    task automatic test_reset_mid;
        set_time(6, 0, 50, 12, 34, 56);
        repeat (2) step(0, 1, 0);
        want("in set_s", 1, 24'h123456, 3'b111, 3'b001, 0, 0, 3'd3);
        step(0, 1, 0);
        step(0, 0, 0);
        #1;
        rst_N = 1'b0;
        want("async reset", 0, 24'h000000, 3'b111, 3'b000, 0, 0, 3'd0);
        @(posedge clk);
        #1;
        rst_N = 1'b1;
        repeat (3) step(0, 1, 0);
        want("alarm back to 0600", 1, 24'h060000,
             3'b110, 3'b100, 0, 0, 3'd4);
        step(0, 1, 0);
        repeat (2) step(0, 1, 0);
    endtask

    initial begin
        test_reset;
        test_rollover;
        test_set_hour;
        test_set_min;
        test_timeout;
        test_alarm;
        test_timeout_key;
        test_reset_mid;
        repeat (3) step(0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
